// File: rtl/clink_uart_intf.sv
// Camera Link serial/camera-control block: AXI4-Lite-style register slave driving
// a SerTC UART transmitter, a SerTFG UART receiver and the four CC lines.
module clink_uart_intf #(
  parameter int CLK_FREQ       = 100000000,
  parameter int BAUD           = 9600,
  parameter int AXI_ADDR_WIDTH = 6,
  parameter int AXI_DATA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      sertc,
  input  logic                      sertfg,
  output logic [3:0]                cc
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_TX     = AXI_ADDR_WIDTH'('h00);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_RX     = AXI_ADDR_WIDTH'('h08);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STATUS = AXI_ADDR_WIDTH'('h10);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_CC     = AXI_ADDR_WIDTH'('h18);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // Register-side state
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q, rd_mux;
  logic [3:0]  cc_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q, frame_err_q, overrun_q;
  logic        wr_hs, rd_hs, tx_busy, tx_start;

  // TX state
  uart_state_e      tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             sertc_q, sertc_d;

  // RX state
  uart_state_e      rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [1:0]       sync_q;
  logic             rx_prev_q, rx_in, rx_done;

  logic unused_wdata;
  assign unused_wdata = ^s_axi_wdata[AXI_DATA_WIDTH-1:8];

  assign wr_hs    = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd_hs    = arready_q & s_axi_arvalid;
  assign tx_busy  = (tx_state_q != ST_IDLE);
  assign tx_start = wr_hs && (s_axi_awaddr == ADDR_TX) && !tx_busy;
  assign rx_in    = sync_q[1];

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rdata   = AXI_DATA_WIDTH'(rdata_q);
  assign sertc         = sertc_q;
  assign cc            = cc_q;

  always_comb begin
    unique case (s_axi_araddr)
      ADDR_RX:     rd_mux = {23'd0, rx_valid_q, rx_data_q};
      ADDR_STATUS: rd_mux = {28'd0, overrun_q, frame_err_q, rx_valid_q, tx_busy};
      ADDR_CC:     rd_mux = {28'd0, cc_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      ST_IDLE: if (tx_start) begin
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_shift_d = s_axi_wdata[7:0];
      end
      ST_START: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = ST_DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = 3'd0;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      ST_DATA: if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        else                  tx_bit_d   = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      ST_STOP: if (tx_cnt_q == BIT_LAST) begin
        tx_state_d = ST_IDLE;
        tx_cnt_d   = '0;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: tx_state_d = ST_IDLE;
    endcase
    // Line level is registered from the next state so SerTC never glitches on decode.
    case (tx_state_d)
      ST_START: sertc_d = 1'b0;
      ST_DATA:  sertc_d = tx_shift_d[0];
      default:  sertc_d = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (rx_prev_q && !rx_in) begin
        rx_state_d = ST_START;
        rx_cnt_d   = '0;
      end
      // Half-bit recheck of the start bit rejects glitches and aligns sampling to bit centres.
      ST_START: if (rx_cnt_q == HALF_LAST) begin
        rx_state_d = rx_in ? ST_IDLE : ST_DATA;
        rx_cnt_d   = '0;
        rx_bit_d   = 3'd0;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      ST_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_in, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        else                  rx_bit_d   = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      ST_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_state_d = ST_IDLE;
        rx_cnt_d   = '0;
        rx_done    = 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments; where a flag is both cleared and set below, the later set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q  <= ST_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'd0;
      sertc_q     <= 1'b1;
      rx_state_q  <= ST_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'd0;
      sync_q      <= 2'b11;
      rx_prev_q   <= 1'b1;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      cc_q        <= 4'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      sertc_q    <= sertc_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      sync_q     <= {sync_q[0], sertfg};
      rx_prev_q  <= rx_in;

      awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
      if (wr_hs) begin
        bvalid_q <= 1'b1;
        bresp_q  <= ((s_axi_awaddr == ADDR_TX) && tx_busy) ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (wr_hs && (s_axi_awaddr == ADDR_CC)) cc_q <= s_axi_wdata[3:0];

      arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;
      if (rd_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s_axi_rready) begin
        rvalid_q <= 1'b0;
      end

      if (wr_hs && (s_axi_awaddr == ADDR_STATUS)) begin
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      if (rd_hs && (s_axi_araddr == ADDR_RX)) rx_valid_q <= 1'b0;
      if (rx_done) begin
        if (rx_in) begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
          if (rx_valid_q) overrun_q <= 1'b1;
        end else begin
          frame_err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clink_uart_intf.sv
// Scoreboard bench for clink_uart_intf: register responses and SerTC frames are
// checked by monitors against expectations queued when stimulus is issued.
module tb_clink_uart_intf;

  localparam int CLK_FREQ = 160;
  localparam int BAUD     = 10;
  localparam int DIV      = CLK_FREQ / BAUD;  // 16 cycles per bit

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic [127:0] wdata, rdata;
  logic [1:0]   bresp, rresp;
  logic         arvalid, arready, rvalid, rready;
  logic         sertc, sertfg;
  logic [3:0]   cc;

  int errors = 0;
  int checks = 0;

  logic [1:0]   bq[$];
  logic [127:0] rq[$];
  logic [7:0]   txq[$];

  always #5 clk = ~clk;

  clink_uart_intf #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .AXI_ADDR_WIDTH(6), .AXI_DATA_WIDTH(128)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .sertc(sertc), .sertfg(sertfg), .cc(cc)
  );

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] exp);
    bit ok = 0;
    bq.push_back(exp);
    awaddr = a; wdata = {96'd0, d}; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    if (!ok) fail_now("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [5:0] a, input logic [31:0] exp);
    bit ok = 0;
    rq.push_back({96'd0, exp});
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) fail_now("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      sertfg = bits[k];
      repeat (DIV) @(posedge clk);
      #1;
    end
    sertfg = 1'b1;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write-response monitor
  always @(negedge clk) begin
    if (!reset && bvalid) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_b bresp=%0d", bresp);
      end else begin
        check("bresp", bresp, bq.pop_front());
      end
    end
  end

  // Read-data monitor
  always @(negedge clk) begin
    if (!reset && rvalid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_r rdata=0x%0h", rdata);
      end else begin
        check("rdata", {rresp, rdata}, {2'b00, rq.pop_front()});
      end
    end
  end

  // SerTC monitor: decodes each frame at bit centres and measures the first low run.
  initial begin : tx_mon
    logic       prev;
    logic [9:0] bits;
    logic [8:0] v;
    logic [7:0] exp;
    int         rise, tz;
    bit         aborted;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev && !sertc) begin
        rise = -1; bits = '0; aborted = 0;
        for (int i = 0; i <= 9 * DIV + DIV / 2; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin aborted = 1; break; end
          if (rise < 0 && sertc) rise = i;
          if (i % DIV == DIV / 2) bits[i / DIV] = sertc;
        end
        if (txq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx_frame bits=0x%0h", bits);
        end else begin
          exp = txq.pop_front();
          if (!aborted) begin
            v = {1'b1, exp};
            tz = 0;
            for (int k = 0; k < 9; k++) begin
              if (v[k]) break;
              tz++;
            end
            check("tx_frame", bits, {1'b1, exp, 1'b0});
            check("tx_low_run", rise, DIV * (1 + tz));
          end
        end
      end
      prev = sertc;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; sertfg = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; bready = 1'b1;
    araddr = '0; arvalid = 0; rready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sertc", sertc, 1'b1);
    check("rst_cc", cc, 4'h0);
    check("rst_valids", {bvalid, rvalid, awready, wready, arready}, 5'b0);
    check("rst_rdata", {bresp, rresp, rdata}, 132'd0);
    reset = 1'b0;
    wait_cycles(4);

    axi_read(6'h10, 32'h0);
    axi_read(6'h18, 32'h0);

    // 0x48: LSB-first bits 0,0,0,1,0,0,1,0 framed by start 0 / stop 1
    txq.push_back(8'h48);
    axi_write(6'h00, 32'h48, 2'b00);
    wait_cycles(5 * DIV);
    axi_read(6'h10, 32'h1);
    wait_cycles(6 * DIV);
    axi_read(6'h10, 32'h0);

    // Second byte during a busy frame is dropped with SLVERR
    txq.push_back(8'h55);
    axi_write(6'h00, 32'h55, 2'b00);
    axi_write(6'h00, 32'hAA, 2'b10);
    wait_cycles(11 * DIV);

    // RX good frame, then read-clear of rx_valid
    rx_frame(8'h3C, 1'b1);
    axi_read(6'h08, 32'h13C);
    axi_read(6'h08, 32'h03C);

    // Framing error leaves rx_data untouched; STATUS write clears it
    rx_frame(8'h81, 1'b0);
    axi_read(6'h10, 32'h4);
    axi_read(6'h08, 32'h03C);
    axi_write(6'h10, 32'h0, 2'b00);
    axi_read(6'h10, 32'h0);

    // Overrun: second byte overwrites the unread first one
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    axi_read(6'h10, 32'hA);
    axi_read(6'h08, 32'h122);

    // Camera-control lines and unmapped offsets
    axi_write(6'h18, 32'hA, 2'b00);
    check("cc_pins", cc, 4'b1010);
    axi_read(6'h18, 32'hA);
    axi_write(6'h28, 32'hFFFF_FFFF, 2'b00);
    axi_read(6'h20, 32'h0);
    axi_read(6'h18, 32'hA);

    // Reset in the middle of a frame
    txq.push_back(8'h5A);
    axi_write(6'h00, 32'h5A, 2'b00);
    wait_cycles(3 * DIV);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midframe_rst_sertc", sertc, 1'b1);
    check("midframe_rst_cc", cc, 4'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_cycles(4);
    axi_read(6'h10, 32'h0);
    txq.push_back(8'hC3);
    axi_write(6'h00, 32'hC3, 2'b00);
    wait_cycles(11 * DIV);

    wait_cycles(10);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    check("txq_drained", txq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
